// File: rtl/register_alias_table.sv
// Register alias table for a dual-issue rename stage: 32 {busy, tag, value}
// entries, four registered source lookups, and CDB snooping to retire aliases.
module rat_lookup #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 3
) (
    input  logic             busy,
    input  logic [TAG_W-1:0] tag,
    input  logic [XLEN-1:0]  value,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    input  logic             fwd,
    input  logic [TAG_W-1:0] fwd_tag,
    output logic             ready,
    output logic [XLEN-1:0]  val,
    output logic [TAG_W-1:0] src_tag
);
    always_comb begin
        ready   = 1'b1;
        val     = value;
        src_tag = '0;
        if (fwd) begin
            // same-group producer on port A shadows whatever the table says
            ready   = 1'b0;
            val     = '0;
            src_tag = fwd_tag;
        end else if (busy && cdb_valid && tag == cdb_tag) begin
            val     = cdb_data;
        end else if (busy) begin
            ready   = 1'b0;
            val     = '0;
            src_tag = tag;
        end
    end
endmodule

module register_alias_table #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [4:0]       a_rs1,
    input  logic [4:0]       a_rs2,
    input  logic [4:0]       a_rd,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    input  logic [4:0]       b_rs1,
    input  logic [4:0]       b_rs2,
    input  logic [4:0]       b_rd,
    input  logic [TAG_W-1:0] b_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             a_out_valid,
    output logic             a_src1_ready,
    output logic [XLEN-1:0]  a_src1_val,
    output logic [TAG_W-1:0] a_src1_tag,
    output logic             a_src2_ready,
    output logic [XLEN-1:0]  a_src2_val,
    output logic [TAG_W-1:0] a_src2_tag,
    output logic             b_out_valid,
    output logic             b_src1_ready,
    output logic [XLEN-1:0]  b_src1_val,
    output logic [TAG_W-1:0] b_src1_tag,
    output logic             b_src2_ready,
    output logic [XLEN-1:0]  b_src2_val,
    output logic [TAG_W-1:0] b_src2_tag,
    output logic [5:0]       busy_count,
    output logic             rat_idle
);
    localparam int NUM_SRC = 4;

    logic [31:0]                busy_q, busy_n;
    logic [31:0][TAG_W-1:0]     tag_q, tag_n;
    logic [31:0][XLEN-1:0]      val_q, val_n;
    logic [5:0]                 count_n;

    logic [NUM_SRC-1:0][4:0]       src_reg;
    logic [NUM_SRC-1:0]            fwd, cap;
    logic [NUM_SRC-1:0]            lk_ready, rdy_q;
    logic [NUM_SRC-1:0][XLEN-1:0]  lk_val, sval_q;
    logic [NUM_SRC-1:0][TAG_W-1:0] lk_tag, stag_q;
    logic [1:0]                    vld_pipe;

    // source order: a_rs1, a_rs2, b_rs1, b_rs2
    assign src_reg = {b_rs2, b_rs1, a_rs2, a_rs1};
    assign cap     = {b_valid, b_valid, a_valid, a_valid};
    assign fwd[0]  = 1'b0;
    assign fwd[1]  = 1'b0;
    assign fwd[2]  = a_valid && (a_rd != 5'd0) && (b_rs1 == a_rd);
    assign fwd[3]  = a_valid && (a_rd != 5'd0) && (b_rs2 == a_rd);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        rat_lookup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_lookup (
            .busy      (busy_q[src_reg[g]]),
            .tag       (tag_q[src_reg[g]]),
            .value     (val_q[src_reg[g]]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .fwd       (fwd[g]),
            .fwd_tag   (a_tag),
            .ready     (lk_ready[g]),
            .val       (lk_val[g]),
            .src_tag   (lk_tag[g])
        );
    end

    // retire first, then renames A and B so a same-cycle rename keeps the entry busy
    always_comb begin
        busy_n = busy_q;
        tag_n  = tag_q;
        val_n  = val_q;
        if (cdb_valid) begin
            for (int i = 1; i < 32; i++) begin
                if (busy_q[i] && tag_q[i] == cdb_tag) begin
                    busy_n[i] = 1'b0;
                    val_n[i]  = cdb_data;
                end
            end
        end
        if (a_valid && a_rd != 5'd0) begin
            busy_n[a_rd] = 1'b1;
            tag_n[a_rd]  = a_tag;
        end
        if (b_valid && b_rd != 5'd0) begin
            busy_n[b_rd] = 1'b1;
            tag_n[b_rd]  = b_tag;
        end
    end

    always_comb begin
        count_n = '0;
        for (int i = 0; i < 32; i++) count_n = count_n + 6'(busy_n[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            tag_q      <= '0;
            val_q      <= '0;
            vld_pipe   <= '0;
            rdy_q      <= '0;
            sval_q     <= '0;
            stag_q     <= '0;
            busy_count <= '0;
            rat_idle   <= 1'b1;
        end else begin
            busy_q     <= busy_n;
            tag_q      <= tag_n;
            val_q      <= val_n;
            vld_pipe   <= {b_valid, a_valid};
            busy_count <= count_n;
            rat_idle   <= (count_n == 6'd0);
            for (int s = 0; s < NUM_SRC; s++) begin
                if (cap[s]) begin
                    rdy_q[s]  <= lk_ready[s];
                    sval_q[s] <= lk_val[s];
                    stag_q[s] <= lk_tag[s];
                end
            end
        end
    end

    assign a_out_valid  = vld_pipe[0];
    assign b_out_valid  = vld_pipe[1];
    assign a_src1_ready = rdy_q[0];
    assign a_src1_val   = sval_q[0];
    assign a_src1_tag   = stag_q[0];
    assign a_src2_ready = rdy_q[1];
    assign a_src2_val   = sval_q[1];
    assign a_src2_tag   = stag_q[1];
    assign b_src1_ready = rdy_q[2];
    assign b_src1_val   = sval_q[2];
    assign b_src1_tag   = stag_q[2];
    assign b_src2_ready = rdy_q[3];
    assign b_src2_val   = sval_q[3];
    assign b_src2_tag   = stag_q[3];
endmodule

// File: tb/tb_register_alias_table.sv
// Bench for register_alias_table: directed vector table, reset-race sequence,
// then constrained-random traffic against a table-level reference model.
module tb_register_alias_table;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, cdb_valid;
    logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [2:0]  a_tag, b_tag, cdb_tag;
    logic [31:0] cdb_data;
    logic        a_out_valid, a_src1_ready, a_src2_ready;
    logic        b_out_valid, b_src1_ready, b_src2_ready;
    logic [31:0] a_src1_val, a_src2_val, b_src1_val, b_src2_val;
    logic [2:0]  a_src1_tag, a_src2_tag, b_src1_tag, b_src2_tag;
    logic [5:0]  busy_count;
    logic        rat_idle;

    register_alias_table #(.XLEN(32), .TAG_W(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rd(a_rd), .a_tag(a_tag),
        .b_valid(b_valid), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_rd(b_rd), .b_tag(b_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .a_out_valid(a_out_valid),
        .a_src1_ready(a_src1_ready), .a_src1_val(a_src1_val), .a_src1_tag(a_src1_tag),
        .a_src2_ready(a_src2_ready), .a_src2_val(a_src2_val), .a_src2_tag(a_src2_tag),
        .b_out_valid(b_out_valid),
        .b_src1_ready(b_src1_ready), .b_src1_val(b_src1_val), .b_src1_tag(b_src1_tag),
        .b_src2_ready(b_src2_ready), .b_src2_val(b_src2_val), .b_src2_tag(b_src2_tag),
        .busy_count(busy_count), .rat_idle(rat_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [4:0] ars1, ars2, ard; logic [2:0] atag;
        logic bv; logic [4:0] brs1, brs2, brd; logic [2:0] btag;
        logic cv; logic [2:0] ctag; logic [31:0] cdata;
    } in_t;

    // ex[s]: expected value when er[s]=1, expected tag when er[s]=0; s = a1,a2,b1,b2
    typedef struct {
        in_t in; logic eav, ebv; logic [3:0] er; logic [31:0] ex[4];
        logic [5:0] ebc; logic eidle;
    } vec_t;

    int checks = 0, errors = 0;

    logic [3:0]  g_r;
    logic [31:0] g_v[4];
    logic [2:0]  g_t[4];
    assign g_r = {b_src2_ready, b_src1_ready, a_src2_ready, a_src1_ready};
    assign g_v[0] = a_src1_val; assign g_v[1] = a_src2_val;
    assign g_v[2] = b_src1_val; assign g_v[3] = b_src2_val;
    assign g_t[0] = a_src1_tag; assign g_t[1] = a_src2_tag;
    assign g_t[2] = b_src1_tag; assign g_t[3] = b_src2_tag;

    // reference model: architectural table plus held operand bundles
    logic        m_busy[32];
    logic [2:0]  m_tag[32];
    logic [31:0] m_val[32];
    logic        m_av, m_bv;
    logic        m_r[4];
    logic [31:0] m_v[4];
    logic [2:0]  m_t[4];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0; m_tag[i] = '0; m_val[i] = '0;
        end
        m_av = 1'b0; m_bv = 1'b0;
        for (int s = 0; s < 4; s++) begin
            m_r[s] = 1'b0; m_v[s] = '0; m_t[s] = '0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_look(input in_t x, input bit is_b, input logic [4:0] r,
                              output logic rdy, output logic [31:0] v, output logic [2:0] t);
        rdy = 1'b1; v = m_val[r]; t = '0;
        if (is_b && x.av && x.ard != 0 && r == x.ard) begin
            rdy = 1'b0; t = x.atag;
        end else if (m_busy[r]) begin
            if (x.cv && m_tag[r] == x.ctag) v = x.cdata;
            else begin rdy = 1'b0; t = m_tag[r]; end
        end
    endtask

    task automatic model_step(input in_t x);
        logic [4:0] rs[4];
        rs[0] = x.ars1; rs[1] = x.ars2; rs[2] = x.brs1; rs[3] = x.brs2;
        for (int s = 0; s < 4; s++)
            if ((s < 2) ? x.av : x.bv) model_look(x, s >= 2, rs[s], m_r[s], m_v[s], m_t[s]);
        m_av = x.av; m_bv = x.bv;
        for (int i = 1; i < 32; i++)
            if (x.cv && m_busy[i] && m_tag[i] == x.ctag) begin
                m_busy[i] = 1'b0; m_val[i] = x.cdata;
            end
        if (x.av && x.ard != 0) begin m_busy[x.ard] = 1'b1; m_tag[x.ard] = x.atag; end
        if (x.bv && x.brd != 0) begin m_busy[x.brd] = 1'b1; m_tag[x.brd] = x.btag; end
    endtask

    task automatic check_model(input string nm);
        chk({nm, " a_out_valid"}, 32'(a_out_valid), 32'(m_av));
        chk({nm, " b_out_valid"}, 32'(b_out_valid), 32'(m_bv));
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("%s src%0d ready", nm, s), 32'(g_r[s]), 32'(m_r[s]));
            if (m_r[s]) chk($sformatf("%s src%0d val", nm, s), g_v[s], m_v[s]);
            else        chk($sformatf("%s src%0d tag", nm, s), 32'(g_t[s]), 32'(m_t[s]));
        end
        chk({nm, " busy_count"}, 32'(busy_count), 32'(model_count()));
        chk({nm, " rat_idle"}, 32'(rat_idle), 32'(model_count() == 0));
    endtask

    task automatic drive(input in_t x);
        a_valid = x.av; a_rs1 = x.ars1; a_rs2 = x.ars2; a_rd = x.ard; a_tag = x.atag;
        b_valid = x.bv; b_rs1 = x.brs1; b_rs2 = x.brs2; b_rd = x.brd; b_tag = x.btag;
        cdb_valid = x.cv; cdb_tag = x.ctag; cdb_data = x.cdata;
    endtask

    // inputs change on negedge; outputs are sampled on the following negedge
    task automatic apply(input in_t x);
        drive(x);
        model_step(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic in_t mki(logic av, logic [4:0] ars1, logic [4:0] ars2, logic [4:0] ard,
                                logic [2:0] atag, logic bv, logic [4:0] brs1, logic [4:0] brs2,
                                logic [4:0] brd, logic [2:0] btag, logic cv, logic [2:0] ctag,
                                logic [31:0] cdata);
        in_t x;
        x.av = av; x.ars1 = ars1; x.ars2 = ars2; x.ard = ard; x.atag = atag;
        x.bv = bv; x.brs1 = brs1; x.brs2 = brs2; x.brd = brd; x.btag = btag;
        x.cv = cv; x.ctag = ctag; x.cdata = cdata;
        return x;
    endfunction

    function automatic vec_t mkv(in_t x, logic eav, logic ebv, logic [3:0] er,
                                 logic [31:0] x0, logic [31:0] x1, logic [31:0] x2,
                                 logic [31:0] x3, logic [5:0] ebc, logic eidle);
        vec_t v;
        v.in = x; v.eav = eav; v.ebv = ebv; v.er = er;
        v.ex[0] = x0; v.ex[1] = x1; v.ex[2] = x2; v.ex[3] = x3;
        v.ebc = ebc; v.eidle = eidle;
        return v;
    endfunction

    task automatic rand_in(output in_t x);
        logic [7:0] used;
        logic [2:0] q[$];
        int n;
        x = mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        used = '0;
        n = 0;
        for (int i = 1; i < 32; i++) if (m_busy[i]) begin used[m_tag[i]] = 1'b1; n++; end
        x.cv = 1'($urandom_range(0, 1));
        x.cdata = $urandom;
        x.ctag = 3'($urandom_range(0, 7));
        if (x.cv && n > 0 && $urandom_range(0, 3) != 0) begin
            q.delete();
            for (int t = 0; t < 8; t++) if (used[t]) q.push_back(3'(t));
            x.ctag = q[$urandom_range(0, q.size() - 1)];
        end
        if (x.cv) used[x.ctag] = 1'b1;
        x.ars1 = 5'($urandom_range(0, 7)); x.ars2 = 5'($urandom_range(0, 7));
        x.brs1 = 5'($urandom_range(0, 7)); x.brs2 = 5'($urandom_range(0, 7));
        x.ard  = 5'($urandom_range(0, 7)); x.brd  = 5'($urandom_range(0, 7));
        x.av = ($urandom_range(0, 3) != 0);
        x.bv = ($urandom_range(0, 3) != 0);
        q.delete();
        for (int t = 0; t < 8; t++) if (!used[t]) q.push_back(3'(t));
        if (q.size() == 0) x.av = 1'b0;
        else begin x.atag = q[$urandom_range(0, q.size() - 1)]; used[x.atag] = 1'b1; end
        q.delete();
        for (int t = 0; t < 8; t++) if (!used[t]) q.push_back(3'(t));
        if (q.size() == 0) x.bv = 1'b0;
        else x.btag = q[$urandom_range(0, q.size() - 1)];
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " a_out_valid"}, 32'(a_out_valid), 0);
        chk({nm, " b_out_valid"}, 32'(b_out_valid), 0);
        chk({nm, " readies"}, 32'(g_r), 0);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("%s src%0d val", nm, s), g_v[s], 0);
            chk($sformatf("%s src%0d tag", nm, s), 32'(g_t[s]), 0);
        end
        chk({nm, " busy_count"}, 32'(busy_count), 0);
        chk({nm, " rat_idle"}, 32'(rat_idle), 1);
    endtask

    vec_t vt[14];
    in_t  x;

    initial begin
        vt[0]  = mkv(mki(1,1,2,3,1, 0,0,0,0,0, 0,0,0),      1,0,4'b0011, 0,0,0,0, 1,0);
        vt[1]  = mkv(mki(0,0,0,0,0, 1,3,0,0,0, 0,0,0),      0,1,4'b1011, 0,0,1,0, 1,0);
        vt[2]  = mkv(mki(0,0,0,0,0, 0,0,0,0,0, 1,1,'h2A),   0,0,4'b1011, 0,0,1,0, 0,1);
        vt[3]  = mkv(mki(1,3,0,0,0, 0,0,0,0,0, 0,0,0),      1,0,4'b1011, 'h2A,0,1,0, 0,1);
        vt[4]  = mkv(mki(1,0,0,7,4, 1,0,7,0,0, 0,0,0),      1,1,4'b0111, 0,0,0,4, 1,0);
        vt[5]  = mkv(mki(1,0,0,8,0, 1,0,0,8,5, 0,0,0),      1,1,4'b1111, 0,0,0,0, 2,0);
        vt[6]  = mkv(mki(0,0,0,0,0, 1,8,7,0,0, 0,0,0),      0,1,4'b0011, 0,0,5,4, 2,0);
        vt[7]  = mkv(mki(1,0,0,3,2, 0,0,0,0,0, 0,0,0),      1,0,4'b0011, 0,0,5,4, 3,0);
        vt[8]  = mkv(mki(1,3,0,0,0, 0,0,0,0,0, 1,2,'h55),   1,0,4'b0011, 'h55,0,5,4, 2,0);
        vt[9]  = mkv(mki(1,0,0,4,3, 0,0,0,0,0, 0,0,0),      1,0,4'b0011, 0,0,5,4, 3,0);
        vt[10] = mkv(mki(1,0,0,4,6, 1,0,0,0,7, 1,3,'h99),   1,1,4'b1111, 0,0,0,0, 3,0);
        vt[11] = mkv(mki(0,0,0,0,0, 1,4,0,0,0, 0,0,0),      0,1,4'b1011, 0,0,6,0, 3,0);
        vt[12] = mkv(mki(1,8,7,0,0, 1,4,8,0,0, 1,5,'h77),   1,1,4'b1001, 'h77,4,6,'h77, 2,0);
        vt[13] = mkv(mki(1,0,0,9,1, 0,0,0,0,0, 0,0,0),      1,0,4'b1011, 0,0,6,'h77, 3,0);

        rst = 1'b1;
        drive(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vt[i].in);
            chk($sformatf("v%0d a_out_valid", i), 32'(a_out_valid), 32'(vt[i].eav));
            chk($sformatf("v%0d b_out_valid", i), 32'(b_out_valid), 32'(vt[i].ebv));
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("v%0d src%0d ready", i, s), 32'(g_r[s]), 32'(vt[i].er[s]));
                if (vt[i].er[s]) chk($sformatf("v%0d src%0d val", i, s), g_v[s], vt[i].ex[s]);
                else chk($sformatf("v%0d src%0d tag", i, s), 32'(g_t[s]), vt[i].ex[s]);
            end
            chk($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(vt[i].ebc));
            chk($sformatf("v%0d rat_idle", i), 32'(rat_idle), 32'(vt[i].eidle));
            check_model($sformatf("v%0d model", i));
        end

        // reset asserted while x4/x7/x9 are busy and every input strobe is active
        rst = 1'b1;
        drive(mki(1, 4, 7, 10, 2, 1, 9, 4, 11, 3, 1, 4, 'hDEAD));
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_race");
        rst = 1'b0;
        model_reset();
        apply(mki(1, 7, 9, 0, 0, 1, 4, 9, 0, 0, 0, 0, 0));
        check_model("post_rst");

        for (int n = 0; n < 400; n++) begin
            rand_in(x);
            apply(x);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_alias_table.md
Name: register_alias_table

Overview:
- Rename stage directly downstream of the two dispatch units; consumes each unit's final source registers, destination register and tag (valid strobe per unit), at up to two instructions per cycle.
- Holds the architectural register file plus a per-register busy/tag alias.
- Returns, per source operand, either the committed value or the producing tag, for the reservation stations.
- Snoops the common data bus (CDB) to retire aliases.

Parameters:
XLEN, 32, data width of registers and CDB
TAG_W, 3, tag width ({fu_sel, rs_index[1:0]})

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
a_valid  in  1  priority dispatch unit instruction valid (one-cycle pulse)
a_rs1  in  5  source 1 register, priority unit
a_rs2  in  5  source 2 register, priority unit
a_rd  in  5  destination register, priority unit
a_tag  in  TAG_W  reservation-station tag, priority unit
b_valid  in  1  second dispatch unit instruction valid
b_rs1  in  5  source 1 register, second unit
b_rs2  in  5  source 2 register, second unit
b_rd  in  5  destination register, second unit
b_tag  in  TAG_W  reservation-station tag, second unit
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  tag of broadcast result
cdb_data  in  XLEN  broadcast result
a_out_valid  out  1  registered operand bundle valid, port A
a_src1_ready  out  1  1 = a_src1_val holds the value; 0 = wait on a_src1_tag
a_src1_val  out  XLEN  source 1 value
a_src1_tag  out  TAG_W  source 1 producing tag
a_src2_ready, a_src2_val, a_src2_tag  out  1/XLEN/TAG_W  same for source 2
b_out_valid, b_src1_*, b_src2_*  out  as port A  operand bundle, port B
busy_count  out  6  number of registers currently aliased
rat_idle  out  1  busy_count == 0 (feeds end-of-program check)

Behaviour:
- State: 32 entries {busy, tag, value}.
- Reset: all busy=0, value=0, tag=0. All outputs 0, except rat_idle=1.
- Reset wins over every concurrent input.
- x0: never busy; always reads ready with value 0; renames and CDB writes to x0 are ignored.
- Latency: operand bundle is registered, 1 cycle after the valid pulse.
  - x_out_valid is a single-cycle pulse mirroring x_valid delayed by one.
  - Outputs hold their last values when not valid.
- Source lookup uses table state at the start of the cycle, with overrides in this priority (highest first):
  1. Port B only: b_rsN == a_rd, a_valid, a_rd != 0 -> ready=0, tag=a_tag (intra-group RAW).
  2. Entry busy, cdb_valid, and entry tag == cdb_tag -> ready=1, val=cdb_data (same-cycle bypass).
  3. Entry busy -> ready=0, tag=entry tag, val=0.
  4. Otherwise -> ready=1, val=entry value, tag=0.
- Port A sources never see port B's rename from the same cycle.
- Rename, at end of cycle:
  - a_valid & a_rd != 0 -> busy=1, tag=a_tag.
  - Then b_valid & b_rd != 0 -> busy=1, tag=b_tag.
  - a_rd == b_rd: B wins.
  - Source equal to own rd (e.g. add x5,x5,x6): lookup uses the old alias; rename is applied after.
- CDB retire: every entry with busy=1 and tag==cdb_tag gets value<=cdb_data, busy<=0.
  - A rename to the same register in the same cycle wins: busy stays 1 with the new tag, and value is still written.
  - cdb_valid with no matching entry has no table effect.
- busy_count and rat_idle are registered from the post-update table (same edge as the table write).
- No backpressure: the block accepts both ports every cycle.
- Dispatch guarantees tags are unique among in-flight instructions; no checking is done here.

Test Plan:
- Reset, then a_valid with a_rs1=1, a_rs2=2, a_rd=3, a_tag=3'b001 -> next cycle a_out_valid=1, both sources ready with val 0; busy_count=1, rat_idle=0.
- Then b_valid only, with b_rs1=3 -> b_src1_ready=0, b_src1_tag=001. Then cdb_valid, tag 001, data 0x2A -> x3 not busy; subsequent read of x3 is ready with 0x2A; busy_count=0.
- Same cycle: a_rd=7/tag 100, b_rs2=7 -> b_src2_ready=0, tag=100. Also a_rd=b_rd=8 with tags 000/101 -> x8 aliased to 101.
- x3 busy tag 010, then lookup of x3 in the cycle cdb_tag=010, data 0x55 -> ready=1, val=0x55.
- Retire/rename race: x4 busy tag 011; in one cycle cdb tag 011 and a_rd=4 tag 110 -> x4 stays busy with tag 110. Renames to x0 -> x0 stays not busy; busy_count unchanged.
- Assert rst while 3 registers are busy and a_valid/b_valid/cdb_valid are all asserted -> next cycle all outputs 0, rat_idle=1, no entry busy.
